// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI mode-0 responder.
//   - spi_state_e / ST_*  : responder FSM encoding (IDLE, ACTIVE)
//   - CPOL, CPHA          : SPI mode constants (mode 0)
//   - DEFAULT_WIDTH       : default frame length in bits
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_ACTIVE = ACTIVE;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/spi_responder_if.sv
// spi_responder_if: local-bus side of the SPI responder.
//   tx_data/tx_load  -> word to send in a later frame, write strobe
//   tx_ready         <- holding register empty
//   rx_data/rx_valid <- last received word, one-cycle completion pulse
//   abort            <- one-cycle pulse when a frame is cut short
// Modports: slave = responder, master = local bus owner.
interface spi_responder_if
  import spi_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             abort;

  modport slave (
    input  tx_data, tx_load,
    output tx_ready, rx_data, rx_valid, abort
  );

  modport master (
    output tx_data, tx_load,
    input  tx_ready, rx_data, rx_valid, abort
  );

endinterface

// File: rtl/spi_sync.sv
// spi_sync: two-flop synchroniser for one asynchronous input.
//   clk, rst (async active-low), d (async in), q (synchronised out)
//   RST_VAL : value both flops take in reset (the line's idle level)
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 peripheral, oversampled in the clk domain.
//   clk, rst (async active-low)
//   sclk, cs_n, mosi : SPI pins from the initiator (asynchronous)
//   miso             : SPI data out, high-impedance while deselected
//   bus              : local bus (tx holding register, rx word, abort)
//
// state  | meaning
// IDLE   | deselected; miso floats, bit counter held at 0
// ACTIVE | selected; shifting on synchronised sclk edges
module spi_responder
  import spi_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output wire                   miso,
  spi_responder_if.slave        bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             sclk_s, cs_s, mosi_s;
  logic             sclk_d, cs_d;
  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_shift, rx_shift, hold;
  logic             skip_fall;
  logic             tx_ready_q, rx_valid_q, abort_q;
  logic [WIDTH-1:0] rx_data_q;

  spi_sync #(.RST_VAL(CPOL)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  spi_sync #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d(cs_n), .q(cs_s));
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_d <= CPOL;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic wrap, reload, load_ok;
  logic [WIDTH-1:0] rx_next;

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign rx_next   = {rx_shift[WIDTH-2:0], mosi_s};

  // Deselect wins over a coincident sclk edge, so a wrap never completes
  // a frame that is being torn down in the same cycle.
  assign wrap    = (state == ST_ACTIVE) && !cs_rise && sclk_rise && (cnt == LAST);
  assign reload  = ((state == ST_IDLE) && cs_fall) || wrap;
  // A reload empties the holding register in the same cycle, so a
  // coincident load is accepted even if tx_ready was low.
  assign load_ok = bus.tx_load && (tx_ready_q || reload);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      skip_fall  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (cs_fall) begin
            state     <= ST_ACTIVE;
            skip_fall <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rx_shift <= '0;
            abort_q  <= (cnt != '0);
          end else begin
            if (sclk_rise) begin
              rx_shift <= rx_next;
              if (wrap) begin
                cnt        <= '0;
                rx_data_q  <= rx_next;
                rx_valid_q <= 1'b1;
                // The next word's MSB is already on miso; keep it there
                // across the fall that follows this rise.
                skip_fall  <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            if (sclk_fall) begin
              if (skip_fall) skip_fall <= 1'b0;
              else           tx_shift  <= {tx_shift[WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (reload) tx_shift <= tx_ready_q ? '0 : hold;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold       <= '0;
      tx_ready_q <= 1'b1;
    end else if (load_ok) begin
      hold       <= bus.tx_data;
      tx_ready_q <= 1'b0;
    end else if (reload) begin
      tx_ready_q <= 1'b1;
    end
  end

  assign miso         = (state == ST_ACTIVE) ? tx_shift[WIDTH-1] : 1'bz;
  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.abort    = abort_q;

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed stimulus with a scoreboard for spi_responder.
// Stimulus pushes expected rx words (with arrival cycle), miso bits and
// abort tokens; independent monitors pop and compare as the DUT responds.
module tb_spi_responder;
  import spi_pkg::*;

  localparam int W = 8;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  wire  miso;

  spi_responder_if #(.WIDTH(W)) bus_if ();

  spi_responder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .sclk (sclk),
    .cs_n (cs_n),
    .mosi (mosi),
    .miso (miso),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } rx_exp_t;

  rx_exp_t rx_q[$];
  logic    miso_q[$];
  int      abort_pend = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // rx_valid / abort monitor
  rx_exp_t e;
  always @(negedge clk) begin
    if (bus_if.rx_valid) begin
      if (rx_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx_valid: unexpected pulse with data %0h, expected none", bus_if.rx_data);
      end else begin
        e = rx_q.pop_front();
        check("rx_data", 32'(bus_if.rx_data), 32'(e.data));
        check("rx_valid_cycle", cyc, e.cyc);
      end
    end
    if (bus_if.abort) begin
      n_cmp++;
      if (abort_pend == 0) begin
        n_bad++;
        $display("FAIL abort: unexpected pulse, expected none");
      end else begin
        abort_pend--;
      end
    end
  end

  // miso monitor: the initiator samples miso on each sclk rise
  logic mb;
  always @(posedge sclk) begin
    n_cmp++;
    if (miso_q.size() == 0) begin
      n_bad++;
      $display("FAIL miso_bit: sclk rise with no expected bit queued");
    end else begin
      mb = miso_q.pop_front();
      if (miso !== mb) begin
        n_bad++;
        $display("FAIL miso_bit: got %b, expected %b", miso, mb);
      end
    end
  end

  // miso must float shortly after every deselect
  always @(posedge cs_n) begin
    repeat (4) @(negedge clk);
    n_cmp++;
    if (miso !== 1'bz) begin
      n_bad++;
      $display("FAIL miso_float: got %b, expected z", miso);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [W-1:0] d);
    bus_if.tx_data = d;
    bus_if.tx_load = 1'b1;
    tick(1);
    bus_if.tx_load = 1'b0;
  endtask

  task automatic push_miso(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) miso_q.push_back(w[W-1-i]);
  endtask

  // Sends the top n bits of w at clk/10; queues the rx word on the last bit.
  task automatic send_bits(input logic [W-1:0] w, input int n, input bit expect_rx);
    rx_exp_t x;
    for (int i = 0; i < n; i++) begin
      mosi = w[W-1-i];
      tick(5);
      sclk = 1'b1;
      if (expect_rx && i == W - 1) begin
        x.data = w;
        x.cyc  = cyc + 3;
        rx_q.push_back(x);
      end
      tick(5);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(5);
  endtask

  task automatic cs_high();
    tick(5);
    cs_n = 1'b1;
    tick(10);
  endtask

  initial begin
    bus_if.tx_data = '0;
    bus_if.tx_load = 1'b0;
    rst = 1'b0;
    tick(3);
    check("reset_tx_ready", 32'(bus_if.tx_ready), 32'd1);
    check("reset_rx_valid", 32'(bus_if.rx_valid), 32'd0);
    check("reset_rx_data", 32'(bus_if.rx_data), 32'h00);
    check("reset_abort", 32'(bus_if.abort), 32'd0);
    n_cmp++;
    if (miso !== 1'bz) begin
      n_bad++;
      $display("FAIL reset_miso: got %b, expected z", miso);
    end
    rst = 1'b1;
    tick(5);

    // single frame
    load(8'hA5);
    check("single_tx_ready_after_load", 32'(bus_if.tx_ready), 32'd0);
    push_miso(8'hA5, 8);
    cs_low();
    check("single_tx_ready_after_select", 32'(bus_if.tx_ready), 32'd1);
    send_bits(8'h3C, 8, 1'b1);
    cs_high();

    // back-to-back frames under one select
    load(8'h0F);
    push_miso(8'h0F, 8);
    push_miso(8'hF0, 8);
    cs_low();
    check("b2b_tx_ready_first_reload", 32'(bus_if.tx_ready), 32'd1);
    load(8'hF0);
    check("b2b_tx_ready_after_load", 32'(bus_if.tx_ready), 32'd0);
    send_bits(8'h81, 8, 1'b1);
    check("b2b_tx_ready_second_reload", 32'(bus_if.tx_ready), 32'd1);
    send_bits(8'h7E, 8, 1'b1);
    cs_high();

    // empty holding register
    push_miso(8'h00, 8);
    cs_low();
    send_bits(8'hC3, 8, 1'b1);
    cs_high();
    check("empty_tx_ready", 32'(bus_if.tx_ready), 32'd1);
    check("empty_rx_data", 32'(bus_if.rx_data), 32'hC3);

    // abort after 5 bits
    push_miso(8'h00, 5);
    abort_pend++;
    cs_low();
    send_bits(8'hFF, 5, 1'b0);
    cs_high();
    check("abort_rx_data_kept", 32'(bus_if.rx_data), 32'hC3);
    check("abort_seen", abort_pend, 0);

    // overload: second load dropped, then a full frame after the abort
    load(8'h22);
    load(8'h11);
    check("overload_tx_ready", 32'(bus_if.tx_ready), 32'd0);
    push_miso(8'h22, 8);
    cs_low();
    send_bits(8'h55, 8, 1'b1);
    cs_high();
    check("overload_tx_ready_after", 32'(bus_if.tx_ready), 32'd1);
    check("final_rx_data", 32'(bus_if.rx_data), 32'h55);

    tick(10);
    check("rx_queue_drained", rx_q.size(), 0);
    check("miso_queue_drained", miso_q.size(), 0);
    check("abort_pending", abort_pend, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
# spi_responder

SPI mode-0 responder (peripheral side) for the toolkit: receives MOSI frames from an external SPI initiator and returns preloaded words on MISO, MSB first. All SPI pins are oversampled in the single system clock domain. Received words are presented to the local bus as one-cycle `rx_valid` pulses. MISO is a tri-state output that floats whenever the responder is deselected, so several responders can share the line.

## Interface
Parameters:
- `WIDTH`, 8, frame length in bits (≥2)

Ports:
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock from initiator, asynchronous to `clk`.
- `cs_n`  in  1  SPI chip select, active-low, asynchronous.
- `mosi`  in  1  SPI data in, asynchronous.
- `miso`  out  1  SPI data out; `1'bz` while deselected.
- `tx_data`  in  WIDTH  word to transmit in the next frame.
- `tx_load`  in  1  writes `tx_data` into the holding register; ignored when `tx_ready`=0.
- `tx_ready`  out  1  holding register empty.
- `rx_data`  out  WIDTH  last complete received word; held until the next completion.
- `rx_valid`  out  1  one-cycle pulse per completed frame.
- `abort`  out  1  one-cycle pulse when `cs_n` deasserts mid-frame.

## Operation
- Reset values: `miso`=z, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `abort`=0, bit counter=0, state=IDLE, holding and shift registers=0.
- Synchronisation: `sclk`, `cs_n` and `mosi` each pass through a 2-FF synchroniser. Edges are detected against a third registered copy of `sclk`/`cs_n`.
- State IDLE (synced `cs_n`=1): `miso`=z, counter=0.
- Falling edge of synced `cs_n` → ACTIVE:
  - shift register ← holding register if `tx_ready`=0, else all zeros;
  - `tx_ready` ← 1.
- ACTIVE:
  - `miso` = shift[WIDTH-1].
  - Synced `sclk` rise: rx shift ← {rx shift[WIDTH-2:0], synced `mosi`}; counter += 1.
  - Synced `sclk` fall: tx shift ← tx shift << 1.
- On the WIDTH-th rise (counter wraps WIDTH-1 → 0):
  - `rx_data` ← completed word; `rx_valid` pulses;
  - tx shift reloads from holding (or zeros) and `tx_ready` ← 1. The next frame's MSB is driven before the following rise, so back-to-back frames under a continuous `cs_n`=0 work.
  - The fall edge directly following this reload does not shift.
- Synced `cs_n` rise with counter≠0 → IDLE; `abort` pulses; partial word discarded; `rx_data` unchanged; `tx_ready` unchanged.
- Synced `cs_n` rise with counter=0 → IDLE silently.
- `tx_load` arriving in the same cycle as a reload: the reload takes the old holding state first, then the load is accepted, leaving `tx_ready`=0.
- `tx_load` while `tx_ready`=0 is dropped; the holding register is unchanged.
- SCLK edges while in IDLE are ignored.

## Timing
- `sclk` high and low phases must each be ≥4 `clk` cycles, i.e. f_sclk ≤ f_clk/8. Setup of `cs_n` to first `sclk` rise ≥4 `clk` cycles.
- `rx_valid` asserts exactly 3 `clk` cycles after the WIDTH-th `sclk` rise at the pin.
- `miso` changes 3 `clk` cycles after the `sclk` fall or `cs_n` fall at the pin. It returns to z 3 cycles after `cs_n` rise.
- `tx_ready` falls the cycle after an accepted `tx_load`.
- Reset asserted mid-frame forces all outputs to reset values immediately. After deassertion the responder waits in IDLE for a fresh `cs_n` fall.

## Structure
- Package `spi_pkg`: state enum (IDLE, ACTIVE), mode-0 constants (CPOL=0, CPHA=0), default `WIDTH`.
- Sub-module `spi_sync`: parameterised 2-FF synchroniser, instantiated three times. Edge detection stays in `spi_responder`.

## Test plan
- Reset: `rst`=0 → `miso`=z, `tx_ready`=1, `rx_valid`=0, `rx_data`=8'h00.
- Single frame: load 8'hA5; initiator sends 8'h3C at clk/10 → MISO bits 1,0,1,0,0,1,0,1 sampled on the rises; `rx_data`=8'h3C; one `rx_valid` pulse 3 cycles after the 8th rise.
- Back-to-back: load 8'h0F, and load 8'hF0 after the first `tx_ready` rise; 16 SCLKs under a single `cs_n` low → MISO 8'h0F then 8'hF0; two `rx_valid` pulses with 8'h81 then 8'h7E for MOSI 8'h81, 8'h7E.
- Empty holding: no load, frame sent → MISO all zeros; `tx_ready` stays 1.
- Abort: `cs_n` rises after 5 SCLKs → `abort` pulses once; no `rx_valid`; `rx_data` keeps its prior value; the next full frame of 8'h55 is received correctly.
- Tri-state and overload: `cs_n`=1 → `miso`=z. A second `tx_load` of 8'h11 while `tx_ready`=0 is dropped, and the earlier 8'h22 is transmitted.
